// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
//   PC register and IF/ID pipeline register of the MIPS core. Presents the
//   current PC to a combinational instruction memory and registers the
//   returned instruction together with its PC+4 for the decode stage.
//   Jump and branch redirects from decode squash the slot fetched in the
//   redirect cycle. Fetches at or beyond IMEM_WORDS*4 yield a NOP carrying a
//   fault flag, and the PC keeps advancing.
//
// Ports
//   clk, rst_n     clock and asynchronous active-low reset
//   imem_addr      byte address to instruction memory (always pc_q)
//   imem_instr     instruction returned combinationally for imem_addr
//   stall          hold PC and IF/ID contents
//   jump           redirect to {branch_pc4[31:28], jump_index, 2'b00}
//   jump_index     J-format target field
//   branch_taken   redirect to branch_pc4 + sign-extended offset * 4
//   branch_offset  I-format immediate of the branch
//   branch_pc4     PC+4 of the branch or jump held in decode
//   if_id_instr    registered instruction (NOP for bubbles / faults)
//   if_id_pc4      registered PC+4 of if_id_instr
//   if_id_valid    if_id_instr is a real fetch, not a bubble
//   if_id_fault    if_id_instr came from an out-of-range address
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 51
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic [31:0] branch_pc4,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        if_id_fault
);

  // Limit kept two bits wider than the PC so large IMEM_WORDS cannot wrap.
  localparam logic [33:0] IMEM_LIMIT = 34'(IMEM_WORDS) << 2;

  logic [31:0] pc_q;
  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] branch_disp;
  logic [31:0] branch_target;
  logic        oor;

  assign imem_addr     = pc_q;
  assign pc4           = pc_q + 32'd4;
  assign jump_target   = {branch_pc4[31:28], jump_index, 2'b00};
  assign branch_disp   = {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign branch_target = branch_pc4 + branch_disp;
  assign oor           = ({2'b00, pc_q} >= IMEM_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      if_id_fault <= 1'b0;
    end else if (jump) begin
      // Redirects squash the in-flight slot; if_id_pc4 is left untouched.
      pc_q        <= jump_target;
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
      if_id_fault <= 1'b0;
    end else if (branch_taken) begin
      pc_q        <= branch_target;
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
      if_id_fault <= 1'b0;
    end else if (!stall) begin
      pc_q        <= pc4;
      if_id_pc4   <= pc4;
      if_id_valid <= 1'b1;
      if_id_fault <= oor;
      if_id_instr <= oor ? '0 : imem_instr;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

  localparam int unsigned WORDS = 51;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic [31:0] branch_pc4;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        if_id_fault;

  logic [31:0] mem [0:WORDS-1];

  int n_total = 0;
  int n_pass  = 0;

  instruction_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(WORDS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .stall        (stall),
    .jump         (jump),
    .jump_index   (jump_index),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .branch_pc4   (branch_pc4),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .if_id_fault  (if_id_fault)
  );

  always #5 clk = ~clk;

  // Memory returns garbage outside the populated range so masking is visible.
  always_comb begin
    if (imem_addr < WORDS * 4) imem_instr = mem[imem_addr[7:2]];
    else                       imem_instr = 32'hBAD0_0000 ^ imem_addr;
  end

  typedef struct {
    logic        s;
    logic        j;
    logic [25:0] ji;
    logic        b;
    logic [15:0] o;
    logic [31:0] bp;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_v;
    logic        e_f;
  } vec_t;

  function automatic vec_t mkv(logic s, logic j, logic [25:0] ji, logic b,
                               logic [15:0] o, logic [31:0] bp,
                               logic [31:0] pc, logic [31:0] ins,
                               logic [31:0] p4, logic va, logic fa);
    vec_t r;
    r.s = s; r.j = j; r.ji = ji; r.b = b; r.o = o; r.bp = bp;
    r.e_pc = pc; r.e_instr = ins; r.e_pc4 = p4; r.e_v = va; r.e_f = fa;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] p4, input logic va, input logic fa);
    chk({tag, ".imem_addr"}, imem_addr, pc);
    chk({tag, ".instr"}, if_id_instr, ins);
    chk({tag, ".pc4"}, if_id_pc4, p4);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(va));
    chk({tag, ".fault"}, 32'(if_id_fault), 32'(fa));
  endtask

  task automatic drive(input logic s, input logic j, input logic [25:0] ji,
                       input logic b, input logic [15:0] o, input logic [31:0] bp);
    stall = s; jump = j; jump_index = ji; branch_taken = b;
    branch_offset = o; branch_pc4 = bp;
  endtask

  // Reference model state: what the stage should hold, from the rules alone.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_v, m_f;

  task automatic model_step(input logic s, input logic j, input logic [25:0] ji,
                            input logic b, input logic [15:0] o, input logic [31:0] bp);
    longint unsigned pcl;
    int              off_words;
    if (j) begin
      m_pc = (bp & 32'hF000_0000) + 32'(longint'(ji) * 4);
      m_instr = 0; m_v = 0; m_f = 0;
    end else if (b) begin
      off_words = int'($signed(o));
      m_pc = bp + 32'(off_words * 4);
      m_instr = 0; m_v = 0; m_f = 0;
    end else if (!s) begin
      pcl = longint'(m_pc);
      m_f = (pcl >= WORDS * 4);
      m_instr = m_f ? 32'h0 : mem[pcl / 4];
      m_pc4 = m_pc + 32'd4;
      m_pc = m_pc4;
      m_v = 1;
    end
  endtask

  vec_t tbl [22];

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h1D4C_0001;
    mem[1] = 32'h1D4C_0001;
    mem[2] = 32'h0182_1020;

    //             s  j  jidx          b  off       bpc4          pc            instr         pc4         v  f
    tbl[0]  = mkv(0, 0, 26'd0,        0, 16'h0000, 32'h0,        32'h4,        32'h1D4C0001, 32'h4,      1, 0);
    tbl[1]  = mkv(0, 0, 26'd0,        0, 16'h0000, 32'h0,        32'h8,        32'h1D4C0001, 32'h8,      1, 0);
    tbl[2]  = mkv(1, 0, 26'd0,        0, 16'h0000, 32'h0,        32'h8,        32'h1D4C0001, 32'h8,      1, 0);
    tbl[3]  = mkv(1, 0, 26'd0,        0, 16'h0000, 32'h0,        32'h8,        32'h1D4C0001, 32'h8,      1, 0);
    tbl[4]  = mkv(1, 0, 26'd0,        0, 16'h0000, 32'h0,        32'h8,        32'h1D4C0001, 32'h8,      1, 0);
    tbl[5]  = mkv(0, 0, 26'h155,      0, 16'h1234, 32'hFFFF0000, 32'hC,        32'h01821020, 32'hC,      1, 0);
    tbl[6]  = mkv(0, 1, 26'd8,        0, 16'h0000, 32'h30,       32'h20,       32'h0,        32'hC,      0, 0);
    tbl[7]  = mkv(0, 0, 26'd0,        0, 16'h0000, 32'h0,        32'h24,       32'hA0000008, 32'h24,     1, 0);
    tbl[8]  = mkv(0, 0, 26'd0,        1, 16'h0001, 32'h28,       32'h2C,       32'h0,        32'h24,     0, 0);
    tbl[9]  = mkv(0, 0, 26'd0,        1, 16'hFFFE, 32'h28,       32'h20,       32'h0,        32'h24,     0, 0);
    tbl[10] = mkv(1, 1, 26'h10,       1, 16'h0001, 32'h28,       32'h40,       32'h0,        32'h24,     0, 0);
    tbl[11] = mkv(0, 0, 26'd0,        0, 16'h0000, 32'h0,        32'h44,       32'hA0000010, 32'h44,     1, 0);
    tbl[12] = mkv(1, 0, 26'd0,        1, 16'h0002, 32'h10,       32'h18,       32'h0,        32'h44,     0, 0);
    tbl[13] = mkv(0, 1, 26'd51,       0, 16'h0000, 32'h0,        32'hCC,       32'h0,        32'h44,     0, 0);
    tbl[14] = mkv(0, 0, 26'd0,        0, 16'h0000, 32'h0,        32'hD0,       32'h0,        32'hD0,     1, 1);
    tbl[15] = mkv(0, 0, 26'd0,        0, 16'h0000, 32'h0,        32'hD4,       32'h0,        32'hD4,     1, 1);
    tbl[16] = mkv(0, 0, 26'd0,        1, 16'h0000, 32'hC8,       32'hC8,       32'h0,        32'hD4,     0, 0);
    tbl[17] = mkv(0, 0, 26'd0,        0, 16'h0000, 32'h0,        32'hCC,       32'hA0000032, 32'hCC,     1, 0);
    tbl[18] = mkv(0, 0, 26'd0,        0, 16'h0000, 32'h0,        32'hD0,       32'h0,        32'hD0,     1, 1);
    tbl[19] = mkv(0, 1, 26'h3FFFFFF,  0, 16'h0000, 32'hF0000000, 32'hFFFFFFFC, 32'h0,        32'hD0,     0, 0);
    tbl[20] = mkv(0, 0, 26'd0,        0, 16'h0000, 32'h0,        32'h0,        32'h0,        32'h0,      1, 1);
    tbl[21] = mkv(0, 0, 26'd0,        0, 16'h0000, 32'h0,        32'h4,        32'h1D4C0001, 32'h4,      1, 0);

    rst_n = 1'b0;
    drive(0, 0, '0, 0, '0, '0);
    #12;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #5 rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].s, tbl[i].j, tbl[i].ji, tbl[i].b, tbl[i].o, tbl[i].bp);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_pc4,
              tbl[i].e_v, tbl[i].e_f);
    end

    // Advance a couple of fetches so state is non-trivial before the pulse.
    drive(0, 0, '0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_rst", 32'h4, 32'h1D4C0001, 32'h4, 1'b1, 1'b0);

    m_pc = 32'h4; m_instr = 32'h1D4C0001; m_pc4 = 32'h4; m_v = 1; m_f = 0;
    for (int c = 0; c < 400; c++) begin
      logic        s, j, b;
      logic [25:0] ji;
      logic [15:0] o;
      logic [31:0] bp;
      s  = ($urandom % 4) == 0;
      j  = ($urandom % 10) == 0;
      b  = ($urandom % 7) == 0;
      ji = (($urandom % 8) == 0) ? 26'($urandom) : 26'($urandom_range(0, 60));
      bp = (($urandom % 8) == 0) ? 32'($urandom) : 32'($urandom_range(0, 60) * 4);
      o  = (($urandom % 8) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 40)) - 20);
      drive(s, j, ji, b, o, bp);
      model_step(s, j, ji, b, o, bp);
      @(posedge clk); #1;
      chk_all($sformatf("rand%0d", c), m_pc, m_instr, m_pc4, m_v, m_f);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- PC register and IF/ID pipeline register for the MIPS core.
- Drives a byte address to the combinational instruction memory, whose word index is address/4, and registers the returned 32-bit instruction plus PC+4 for the decode stage.
- Accepts stall, jump and branch-redirect requests from decode.
- Flags fetches beyond the populated memory range.

Parameters:
- RESET_PC, 32'h0000_0000: byte address fetched first after reset.
- IMEM_WORDS, 51: number of instruction-memory words. Addresses at or above IMEM_WORDS*4 are out of range.

Ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous active-low reset.
- imem_addr  out  32: byte address to instruction memory; always equals pc_q.
- imem_instr  in  32: instruction returned combinationally for imem_addr.
- stall  in  1: hold PC and IF/ID contents.
- jump  in  1: redirect to the jump target this cycle.
- jump_index  in  26: J-format target field.
- branch_taken  in  1: redirect to the branch target this cycle.
- branch_offset  in  16: I-format immediate of the branch.
- branch_pc4  in  32: PC+4 of the branch instruction held in decode.
- if_id_instr  out  32: registered instruction.
- if_id_pc4  out  32: registered PC+4 of if_id_instr.
- if_id_valid  out  1: if_id_instr is a real fetch, not a bubble.
- if_id_fault  out  1: if_id_instr came from an out-of-range address.

Behaviour:
- One clock (clk) domain. Asynchronous active-low reset (rst_n).
- While rst_n=0:
  - pc_q=RESET_PC
  - if_id_instr=32'h0000_0000 (NOP)
  - if_id_pc4=0
  - if_id_valid=0
  - if_id_fault=0
- imem_addr=pc_q combinationally; zero-cycle memory is assumed by the interface.
- pc4 = pc_q + 32'd4, modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is legal.
- jump_target = {branch_pc4[31:28], jump_index, 2'b00}.
- branch_target = branch_pc4 + ({{14{branch_offset[15]}}, branch_offset, 2'b00}), modulo 2^32.
- oor = (pc_q >= IMEM_WORDS*4), computed as an unsigned compare.
- At each rising edge, evaluate in strict priority order:
  1. jump=1: pc_q<=jump_target; if_id_instr<=0, if_id_valid<=0, if_id_fault<=0; if_id_pc4 holds. Overrides stall and branch_taken.
  2. branch_taken=1: pc_q<=branch_target; IF/ID squashed as in case 1. Overrides stall.
  3. stall=1: pc_q and all if_id_* hold their values.
  4. Otherwise:
     - pc_q<=pc4
     - if_id_pc4<=pc4
     - if_id_valid<=1
     - if_id_fault<=oor
     - if_id_instr<=(oor ? 32'h0 : imem_instr)
- Fetch latency: an instruction at address A appears on if_id_instr one edge after pc_q=A, provided that edge is unstalled and unredirected.
- Redirect penalty: exactly one bubble, the slot fetched in the redirect cycle.
- Out-of-range fetches do not halt the stage. The PC keeps advancing. The fault flag travels with the NOP so that downstream logic can trap.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge. The first edge after deassertion fetches RESET_PC.
- Input sampling: jump_index, branch_offset and branch_pc4 are sampled only when their qualifier (jump or branch_taken) is 1 and are otherwise ignored.
- No combinational path from any input to any output other than imem_instr affecting nothing combinationally; imem_addr depends on pc_q only.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: rst_n=0, then release. Memory word0=32'h1D4C0001, word1=32'h1D4C0001, word2=32'h01821020.
  - Required response: imem_addr 0, 4, 8 on successive cycles. if_id_instr follows one edge later. if_id_pc4 = 4, 8, 12. if_id_valid=1 from the first edge.
- Stall:
  - Stimulus: stall=1 for 3 cycles while pc_q=8.
  - Required response: pc_q stays 8. if_id_instr and if_id_pc4=8 hold. After release, pc_q=12.
- Jump:
  - Stimulus: jump=1, jump_index=26'd8, branch_pc4=32'h30.
  - Required response: next pc_q=32'h20. if_id_valid=0 and if_id_instr=0 for one cycle. The instruction from 32'h20 appears on the following edge.
- Branch, backward and forward:
  - Stimulus: branch_taken=1, branch_pc4=32'h28, offset 16'h0001; then offset 16'hFFFE.
  - Required response: pc_q=32'h2C for the first, pc_q=32'h20 for the second.
- Priority collision:
  - Stimulus: jump=1, branch_taken=1, stall=1 in the same cycle.
  - Required response: pc_q=jump_target and the slot is squashed. Separately, branch_taken with stall gives pc_q=branch_target.
- Out-of-range and async reset:
  - Stimulus: redirect to 32'hCC (IMEM_WORDS=51 → limit 204).
  - Required response: if_id_fault=1, if_id_instr=0, pc_q advances to 32'hD0.
  - Then: pulse rst_n low between clock edges.
  - Required response: all outputs reset immediately, imem_addr=0.
